addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shares one significand adder-subtractor datapath between `NREQ` requesters in the FP add/sub unit. Round-robin arbitration, operand and result registers, and a three-state sequencer. The granted operation drives the shared datapath for exactly one cycle. The result is held under a valid/ready handshake and tagged with the requester index. It sits between the alignment stages of the FP lanes and the single shared significand addsub instance.

## Interface
- `width`, 27, significand width in bits (operands and result)
- `NREQ`, 4, number of requesters, 2..16
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  grant/accept, one-hot or zero
- `req_in1`  in  NREQ*width  operand 1; requester i uses slice [i*width +: width]
- `req_in2`  in  NREQ*width  operand 2, packed the same way
- `req_eop`  in  NREQ  effective operation per requester: 0 = add, 1 = sub
- `dp_in1`, `dp_in2`  out  width  operands to the shared datapath
- `dp_eop`  out  1  operation to the shared datapath
- `dp_res`  in  width  datapath result (combinational from `dp_*`)
- `dp_carry`, `dp_sign_sub`  in  1  datapath carry and sign of subtraction
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `out_res`  out  width  registered result
- `out_carry`, `out_sign_sub`  out  1  registered flags
- `out_id`  out  clog2(NREQ)  index of the requester that owns the result

## Operation
- FSM states: IDLE, EXEC, WAIT. Reset state is IDLE.
- **Grant.** Search starts at `ptr+1` and wraps modulo NREQ. The first asserted `req_valid` wins.
  - `req_ready` is asserted for the winner only, when state = IDLE, or when state = WAIT and `out_ready` = 1.
  - Otherwise `req_ready` = 0.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not gate `req_valid` on `req_ready`.
- **Accept** (`req_valid[i]` & `req_ready[i]` at an edge):
  - capture in1, in2 and eop of requester i into the operand register;
  - set `id` = i and `ptr` = i;
  - go to EXEC.
- **EXEC** (one cycle):
  - `dp_*` are driven from the operand register;
  - at the edge, capture `dp_res`, `dp_carry`, `dp_sign_sub` and `id` into the result register;
  - go to WAIT.
- **WAIT:** `out_valid` = 1 and all `out_*` are stable.
  - `out_ready` = 1 with a new accept: go to EXEC.
  - `out_ready` = 1 with no requester valid: go to IDLE.
  - `out_ready` = 0: stay in WAIT and hold everything.
- `dp_*` always reflect the operand register, including outside EXEC, so the datapath sees no spurious toggles.
- **Datapath contract, checked by the bench model:**
  - add: `res` = (in1+in2) mod 2^width; `carry` = bit `width` of the sum; `sign_sub` = (in2 > in1).
  - sub: `sum` = in1 + (2^width − in2) mod 2^width; `carry` = carry-out of that sum; `res` = `sign_sub` ? −sum : sum, so `res` = |in1 − in2|.

## Timing
- Reset values: `req_ready` = 0 while `rst_n` is low. `out_valid` = 0; `out_res`, `out_carry`, `out_sign_sub`, `out_id` = 0. `dp_in1`, `dp_in2`, `dp_eop` = 0. `ptr` = NREQ−1, so requester 0 has first priority.
- Latency: accept edge N, EXEC during cycle N+1, `out_valid` high from cycle N+2.
- Peak throughput: one op per 2 cycles.
- Reset asserted mid-operation: the in-flight op is dropped and the block is in IDLE immediately. After release, the first accepted request follows normal latency.
- Back-pressure: `out_valid` can stay high indefinitely. No requester is accepted while WAIT is stalled.
- Simultaneous `out_ready` and new request in WAIT: both handshakes occur on the same edge, with no bubble.
- `ptr` changes only on accept. Requesters that are not granted keep their requests pending, so there is no loss.

## Configuration
- `ADDSUB_ARB_FIXED_PRIO_EN` defined:
  - fixed priority, lowest asserted index wins;
  - `ptr` is not implemented;
  - starvation is possible and permitted.
- Not defined: round-robin as described in Operation. This is the default build.

## Test plan
- Single add, NREQ=4, width=27: requester 2 sends in1=100, in2=28, eop=0 → `req_ready`=0100 at edge 0; at cycle 2, `out_valid`=1, `out_res`=128, `out_carry`=0, `out_sign_sub`=0, `out_id`=2.
- Subtract with negative result: in1=5, in2=9, eop=1 → `out_res`=4, `out_sign_sub`=1. Add overflow: in1=in2=0x4000000 → `out_res`=0, `out_carry`=1.
- All four requesters held valid, `out_ready`=1 continuously → grant order 0,1,2,3,0; one accept every 2 cycles. With the macro defined → requester 0 is granted every time.
- Back-pressure: `out_ready`=0 for 5 cycles → `out_*` stable and `req_ready`=0 throughout; raising `out_ready` with requester 1 valid → both handshakes on the same edge, and the next result appears 2 cycles later.
- Reset during EXEC: `rst_n` low for 1 cycle → `out_valid`=0 and all outputs 0 immediately; the dropped op never appears; the next request completes with latency 2.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of one shared significand adder-subtractor, with operand/result registers.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer).
//
// state | meaning
// IDLE  | no operation in flight; a valid request is accepted immediately
// EXEC  | operand register drives the shared datapath; result captured at the edge
// WAIT  | result held on out_*; a new request is accepted only together with out_ready
module addsub_arbiter #(
    parameter int width = 27,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*width-1:0]     req_in1,
    input  logic [NREQ*width-1:0]     req_in2,
    input  logic [NREQ-1:0]           req_eop,
    output logic [width-1:0]          dp_in1,
    output logic [width-1:0]          dp_in2,
    output logic                      dp_eop,
    input  logic [width-1:0]          dp_res,
    input  logic                      dp_carry,
    input  logic                      dp_sign_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          out_res,
    output logic                      out_carry,
    output logic                      out_sign_sub,
    output logic [$clog2(NREQ)-1:0]   out_id
);

    localparam int idw = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

    state_t           state;
    logic [width-1:0] op_in1;
    logic [width-1:0] op_in2;
    logic             op_eop;
    logic [idw-1:0]   op_id;

    logic             gnt_found;
    logic [idw-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             can_grant;
    logic             acc;
    logic [width-1:0] sel_in1;
    logic [width-1:0] sel_in2;
    logic             sel_eop;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = idw'(i);
            end
        end
    end
`else
    logic [idw-1:0] ptr;
    int             cand;
    logic [idw-1:0] cand_idx;

    // Search begins one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = idw'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end
`endif

    // Grant is gated by rst_n so req_ready stays low for the whole reset pulse.
    always_comb begin
        can_grant = rst_n && ((state == IDLE) || ((state == WAIT) && out_ready));
        gnt       = '0;
        if (can_grant && gnt_found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt;
    assign acc       = |gnt;

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        sel_eop = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_in1 = req_in1[i*width +: width];
                sel_in2 = req_in2[i*width +: width];
                sel_eop = req_eop[i];
            end
        end
    end

    // The datapath is fed straight from the operand register so it only toggles on accept.
    assign dp_in1 = op_in1;
    assign dp_in2 = op_in2;
    assign dp_eop = op_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_in1       <= '0;
            op_in2       <= '0;
            op_eop       <= 1'b0;
            op_id        <= '0;
            out_valid    <= 1'b0;
            out_res      <= '0;
            out_carry    <= 1'b0;
            out_sign_sub <= 1'b0;
            out_id       <= '0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
            ptr          <= idw'(NREQ - 1);
`endif
        end else begin
            if (acc) begin
                op_in1 <= sel_in1;
                op_in2 <= sel_in2;
                op_eop <= sel_eop;
                op_id  <= gnt_idx;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
                ptr    <= gnt_idx;
`endif
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_res      <= dp_res;
                    out_carry    <= dp_carry;
                    out_sign_sub <= dp_sign_sub;
                    out_id       <= op_id;
                    out_valid    <= 1'b1;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= acc ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: a behavioural adder-subtractor stands in for the shared datapath.
module tb_addsub_arbiter;

    localparam int W   = 27;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_in1;
    logic [N*W-1:0]   req_in2;
    logic [N-1:0]     req_eop;
    logic [W-1:0]     dp_in1;
    logic [W-1:0]     dp_in2;
    logic             dp_eop;
    logic [W-1:0]     dp_res;
    logic             dp_carry;
    logic             dp_sign_sub;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    logic             out_carry;
    logic             out_sign_sub;
    logic [IDW-1:0]   out_id;

    always #5 clk = ~clk;

    addsub_arbiter #(.width(W), .NREQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_in1      (req_in1),
        .req_in2      (req_in2),
        .req_eop      (req_eop),
        .dp_in1       (dp_in1),
        .dp_in2       (dp_in2),
        .dp_eop       (dp_eop),
        .dp_res       (dp_res),
        .dp_carry     (dp_carry),
        .dp_sign_sub  (dp_sign_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_carry    (out_carry),
        .out_sign_sub (out_sign_sub),
        .out_id       (out_id)
    );

    // Shared datapath, written in two's-complement form.
    logic [W:0]   dsum;
    logic [W-1:0] nin2;
    always_comb begin
        dsum        = '0;
        nin2        = '0;
        dp_res      = '0;
        dp_sign_sub = (dp_in2 > dp_in1);
        if (!dp_eop) begin
            dsum   = {1'b0, dp_in1} + {1'b0, dp_in2};
            dp_res = dsum[W-1:0];
        end else begin
            nin2   = W'(0) - dp_in2;
            dsum   = {1'b0, dp_in1} + {1'b0, nin2};
            dp_res = dp_sign_sub ? (W'(0) - dsum[W-1:0]) : dsum[W-1:0];
        end
        dp_carry = dsum[W];
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   res;
        logic           carry;
        logic           sign;
    } exp_t;

    exp_t sb_q[$];
    int   acc_ids[$];
    int   acc_cycs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_pop_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected result in magnitude form, independent of the datapath model above.
    function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
        exp_t       r;
        logic [W:0] s;
        r.id   = IDW'(id);
        r.sign = (b > a);
        if (!e) begin
            s       = {1'b0, a} + {1'b0, b};
            r.res   = s[W-1:0];
            r.carry = s[W];
        end else begin
            r.res   = (a >= b) ? (a - b) : (b - a);
            r.carry = (b != 0) && (a >= b);
        end
        return r;
    endfunction

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb_q.push_back(model(i, req_in1[i*W +: W], req_in2[i*W +: W], req_eop[i]));
                acc_ids.push_back(i);
                acc_cycs.push_back(cyc);
            end
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("sb_id", out_id, e.id);
                check("sb_res", out_res, e.res);
                check("sb_carry", out_carry, e.carry);
                check("sb_sign", out_sign_sub, e.sign);
                last_pop_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
        logic [N-1:0] oh;
        int           n0;
        int           t;
        oh    = '0;
        oh[i] = 1'b1;
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
        req_eop[i]        = e;
        req_valid[i]      = 1'b1;
        #1;
        check("grant_idle", req_ready, oh);
        n0 = acc_ids.size();
        t  = 0;
        while (acc_ids.size() == n0 && t < 20) begin
            tick();
            t++;
        end
        req_valid[i] = 1'b0;
        check("accept_seen", acc_ids.size(), n0 + 1);
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        check("out_valid_seen", out_valid, 1);
        if (acc_ids.size() > n0) begin
            check("latency", cyc - acc_cycs[$], 2);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] held;
        int           n0;
        int           t;
        int           exp_id;

        rst_n     = 1'b0;
        req_valid = '1;
        req_in1   = '0;
        req_in2   = '0;
        req_eop   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_flags", {out_carry, out_sign_sub}, 0);
        check("rst_dp", {dp_in1, dp_in2, dp_eop}, 0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Single add from requester 2
        run_op(2, 27'd100, 27'd28, 1'b0);
        check("add_res", out_res, 128);
        check("add_carry", out_carry, 0);
        check("add_sign", out_sign_sub, 0);
        check("add_id", out_id, 2);
        check("add_dp_in1", dp_in1, 100);
        drain();
        check("add_consumed", out_valid, 0);

        // Negative subtraction and add overflow
        run_op(1, 27'd5, 27'd9, 1'b1);
        check("sub_res", out_res, 4);
        check("sub_sign", out_sign_sub, 1);
        drain();
        run_op(3, 27'h4000000, 27'h4000000, 1'b0);
        check("ovf_res", out_res, 0);
        check("ovf_carry", out_carry, 1);
        drain();

        // All requesters held valid, consumer always ready
        acc_ids.delete();
        acc_cycs.delete();
        for (int i = 0; i < N; i++) begin
            req_in1[i*W +: W] = W'(1000 * (i + 1));
            req_in2[i*W +: W] = W'(7 * i + 3);
            req_eop[i]        = i[0];
        end
        out_ready = 1'b1;
        req_valid = '1;
        t = 0;
        while (acc_ids.size() < 5 && t < 40) begin
            tick();
            t++;
        end
        req_valid = '0;
        repeat (3) tick();
        out_ready = 1'b0;
        check("rr_count", acc_ids.size(), 5);
        for (int k = 0; k < 5 && k < acc_ids.size(); k++) begin
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = k % N;
`endif
            check("rr_order", acc_ids[k], exp_id);
            if (k > 0) begin
                check("rr_spacing", acc_cycs[k] - acc_cycs[k-1], 2);
            end
        end

        // Back-pressure, then simultaneous output and input handshakes
        run_op(0, 27'd300, 27'd45, 1'b1);
        held = out_res;
        check("bp_res", out_res, 255);
        req_in1[1*W +: W] = 27'd12345;
        req_in2[1*W +: W] = 27'd345;
        req_eop[1]        = 1'b0;
        req_valid[1]      = 1'b1;
        n0 = acc_ids.size();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_hold_res", out_res, held);
            check("bp_hold_id", out_id, 0);
            check("bp_no_grant", req_ready, 0);
        end
        check("bp_no_accept", acc_ids.size(), n0);
        out_ready = 1'b1;
        #1;
        check("bp_release_grant", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        check("bp_accept", acc_ids.size(), n0 + 1);
        if (acc_ids.size() > n0) begin
            check("bp_same_edge", acc_cycs[$], last_pop_cyc);
        end
        check("bp_exec_gap", out_valid, 0);
        out_ready = 1'b0;
        tick();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_id", out_id, 1);
        check("bp_next_res", out_res, 12690);
        if (acc_ids.size() > n0) begin
            check("bp_next_latency", cyc - acc_cycs[$], 2);
        end
        drain();

        // Reset while the operation is in EXEC
        req_in1[2*W +: W] = 27'd77;
        req_in2[2*W +: W] = 27'd11;
        req_eop[2]        = 1'b0;
        req_valid[2]      = 1'b1;
        n0 = acc_ids.size();
        tick();
        req_valid    = 4'b0010;
        check("mid_accept", acc_ids.size(), n0 + 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_res", out_res, 0);
        check("mid_rst_id", out_id, 0);
        check("mid_rst_dp", {dp_in1, dp_in2, dp_eop}, 0);
        check("mid_rst_ready", req_ready, 0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        req_in1[3*W +: W] = 27'd9;
        req_in2[3*W +: W] = 27'd9;
        req_valid = 4'b1001;
        #1;
        check("post_rst_prio", req_ready, 4'b0001);
        req_valid = '0;
        run_op(0, 27'd40, 27'd2, 1'b1);
        check("post_rst_res", out_res, 38);
        check("post_rst_id", out_id, 0);
        drain();
        repeat (3) tick();
        check("end_idle", out_valid, 0);
        check("end_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
